// File: rtl/rc_channel_sequencer.sv
// rc_channel_sequencer: shares one pulse-to-value converter among NUM_CH
// pwm_reader channels. It latches each channel's pulse length, picks the next
// channel round-robin, runs a req/ack handshake with the converter, and stores
// the 8-bit result for each channel.
// Optional feature: define RC_FAILSAFE_EN to enable the ch0 (throttle) link-loss
// watchdog. Without it, link_ok rises one cycle after reset release and stays high.
//
// state | meaning
// IDLE  | no conversion in flight; grant the next pending channel if there is one
// REQ   | conv_req high for channel sel_q, waiting for conv_ack
module rc_channel_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int PW_W       = 16,
  parameter int MIN_US     = 1000,
  parameter int MAX_US     = 2000,
  parameter int TIMEOUT_US = 60000
) (
  input  logic                   us_clk,
  input  logic                   resetn,
  input  logic [NUM_CH*PW_W-1:0] pulse_us,
  input  logic [NUM_CH-1:0]      pulse_valid,
  output logic                   conv_req,
  output logic [PW_W-1:0]        conv_pulse_us,
  input  logic                   conv_ack,
  input  logic [7:0]             conv_value,
  output logic [NUM_CH*8-1:0]    ch_val,
  output logic [NUM_CH-1:0]      ch_fresh,
  output logic                   link_ok
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  conv_req_q, conv_req_d;
  logic [PW_W-1:0]       conv_pulse_q, conv_pulse_d;
  logic [NUM_CH-1:0]     pending_q, pending_d;
  logic [NUM_CH*8-1:0]   ch_val_q, ch_val_d;
  logic [NUM_CH-1:0]     ch_fresh_q, ch_fresh_d;
  logic                  link_ok_q, link_ok_d;
  logic [PW_W-1:0]       shadow_q [NUM_CH];

  logic [NUM_CH-1:0]     eff_pending;
  logic                  grant_any;
  logic [SEL_W-1:0]      grant_sel;
  logic [SEL_W:0]        cand_sum;
  logic [PW_W-1:0]       grant_pw;
  logic                  drop_ch0;
  logic                  wd_expire;

`ifdef RC_FAILSAFE_EN
  localparam int WD_W = $clog2(TIMEOUT_US + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
`endif

  function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] v);
    if (v < PW_W'(MIN_US)) return PW_W'(MIN_US);
    if (v > PW_W'(MAX_US)) return PW_W'(MAX_US);
    return v;
  endfunction

  // Latch the most recent pulse length per channel; a newer sample overwrites an older one.
  always_ff @(posedge us_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!resetn) shadow_q[i] <= '0;
      else if (pulse_valid[i]) shadow_q[i] <= pulse_us[i*PW_W +: PW_W];
    end
  end

  // Round-robin pick: first pending channel at or after rr_ptr. A strobe arriving
  // this cycle counts as pending so a grant can follow the strobe by one cycle.
  always_comb begin
    eff_pending = pending_q | pulse_valid;
    grant_any   = 1'b0;
    grant_sel   = '0;
    cand_sum    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
      if (cand_sum >= (SEL_W+1)'(NUM_CH)) cand_sum = cand_sum - (SEL_W+1)'(NUM_CH);
      if (!grant_any && eff_pending[cand_sum[SEL_W-1:0]]) begin
        grant_any = 1'b1;
        grant_sel = cand_sum[SEL_W-1:0];
      end
    end
    grant_pw = pulse_valid[grant_sel] ? pulse_us[int'(grant_sel)*PW_W +: PW_W]
                                      : shadow_q[grant_sel];
  end

  // Link supervision: watchdog on ch0 strobes when enabled, otherwise link is always healthy.
  always_comb begin
`ifdef RC_FAILSAFE_EN
    wd_expire = !pulse_valid[0] && (wdog_q == WD_W'(TIMEOUT_US - 1));
    wdog_d    = wdog_q;
    if (pulse_valid[0])                    wdog_d = '0;
    else if (wdog_q != WD_W'(TIMEOUT_US))  wdog_d = wdog_q + 1'b1;
    link_ok_d = link_ok_q;
    if (pulse_valid[0]) link_ok_d = 1'b1;
    else if (wd_expire) link_ok_d = 1'b0;
    drop_ch0  = !link_ok_q || wd_expire;
`else
    wd_expire = 1'b0;
    link_ok_d = 1'b1;
    drop_ch0  = 1'b0;
`endif
  end

  // Sequencer next state: grant in IDLE, hold the request in REQ until ack.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    conv_req_d   = conv_req_q;
    conv_pulse_d = conv_pulse_q;
    pending_d    = pending_q | pulse_valid;
    ch_val_d     = ch_val_q;
    ch_fresh_d   = '0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          sel_d                = grant_sel;
          conv_pulse_d         = clamp_pw(grant_pw);
          conv_req_d           = 1'b1;
          pending_d[grant_sel] = 1'b0;
          state_d              = REQ;
        end
      end
      REQ: begin
        if (conv_ack) begin
          conv_req_d = 1'b0;
          rr_ptr_d   = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
          state_d    = IDLE;
          // A throttle result arriving while the link is down would undo the failsafe value.
          if (!((sel_q == '0) && drop_ch0)) begin
            ch_val_d[int'(sel_q)*8 +: 8] = conv_value;
            ch_fresh_d[sel_q]            = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (wd_expire) begin
      ch_val_d[7:0] = 8'd0;
      ch_fresh_d[0] = 1'b1;
    end
  end

  // State and output registers; reset abandons any in-flight handshake.
  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      rr_ptr_q     <= '0;
      conv_req_q   <= 1'b0;
      conv_pulse_q <= '0;
      pending_q    <= '0;
      ch_val_q     <= '0;
      ch_fresh_q   <= '0;
      link_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      conv_req_q   <= conv_req_d;
      conv_pulse_q <= conv_pulse_d;
      pending_q    <= pending_d;
      ch_val_q     <= ch_val_d;
      ch_fresh_q   <= ch_fresh_d;
      link_ok_q    <= link_ok_d;
    end
  end

`ifdef RC_FAILSAFE_EN
  // Watchdog register, saturating at TIMEOUT_US so the loss event fires once.
  always_ff @(posedge us_clk) begin
    if (!resetn) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`endif

  assign conv_req      = conv_req_q;
  assign conv_pulse_us = conv_pulse_q;
  assign ch_val        = ch_val_q;
  assign ch_fresh      = ch_fresh_q;
  assign link_ok       = link_ok_q;

endmodule

// File: tb/tb_rc_channel_sequencer.sv
// Directed bench for rc_channel_sequencer (NUM_CH=4, PW_W=16).
module tb_rc_channel_sequencer;

  logic        us_clk = 1'b0;
  logic        resetn;
  logic [63:0] pulse_us;
  logic [3:0]  pulse_valid;
  logic        conv_req;
  logic [15:0] conv_pulse_us;
  logic        conv_ack;
  logic [7:0]  conv_value;
  logic [31:0] ch_val;
  logic [3:0]  ch_fresh;
  logic        link_ok;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_val;

  rc_channel_sequencer dut (
    .us_clk(us_clk), .resetn(resetn), .pulse_us(pulse_us), .pulse_valid(pulse_valid),
    .conv_req(conv_req), .conv_pulse_us(conv_pulse_us), .conv_ack(conv_ack),
    .conv_value(conv_value), .ch_val(ch_val), .ch_fresh(ch_fresh), .link_ok(link_ok)
  );

  always #5 us_clk = ~us_clk;

  // Wait (bounded) for a request, observe it for 'delay' cycles, then ack with 'val'.
  task automatic serve(input int delay, input logic [7:0] val, output int waits,
                       output logic [15:0] pw, output bit stable,
                       output logic [3:0] fresh, output logic req_after);
    waits = 0;
    while (conv_req !== 1'b1 && waits < 20) begin
      @(negedge us_clk);
      waits++;
    end
    pw = conv_pulse_us;
    stable = 1'b1;
    fresh = '0;
    req_after = 1'bx;
    if (conv_req !== 1'b1) begin
      stable = 1'b0;
      return;
    end
    repeat (delay) begin
      @(negedge us_clk);
      if (conv_req !== 1'b1 || conv_pulse_us !== pw) stable = 1'b0;
    end
    conv_value = val;
    conv_ack = 1'b1;
    @(negedge us_clk);
    fresh = ch_fresh;
    req_after = conv_req;
    conv_ack = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    pulse_valid = '0;
    pulse_us = '0;
    conv_ack = 1'b0;
    conv_value = '0;
    exp_val = '0;
    repeat (3) @(negedge us_clk);
    tests_run++;
    if ({conv_req, conv_pulse_us, ch_val, ch_fresh, link_ok} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: req=%b pw=%0d val=%h fresh=%b link=%b, want all zero",
               conv_req, conv_pulse_us, ch_val, ch_fresh, link_ok);
    end
    resetn = 1'b1;
    @(negedge us_clk);
    tests_run++;
`ifdef RC_FAILSAFE_EN
    if (link_ok !== 1'b0) begin
`else
    if (link_ok !== 1'b1) begin
`endif
      tests_failed++;
      $display("FAIL link_after_release: link_ok=%b", link_ok);
    end
  endtask

  task automatic test_basic();
    int w; logic [15:0] pw; bit st; logic [3:0] fr; logic ra;
    pulse_us[31:16] = 16'd1500;
    pulse_valid = 4'b0010;
    @(negedge us_clk);
    pulse_valid = '0;
    tests_run++;
    if (conv_req !== 1'b1 || conv_pulse_us !== 16'd1500) begin
      tests_failed++;
      $display("FAIL basic_latency: req=%b pw=%0d, want req=1 pw=1500", conv_req, conv_pulse_us);
    end
    serve(0, 8'd128, w, pw, st, fr, ra);
    exp_val[15:8] = 8'd128;
    tests_run++;
    if (fr !== 4'b0010 || ch_val !== exp_val || ra !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_result: fresh=%b val=%h req=%b, want fresh=0010 val=%h req=0",
               fr, ch_val, ra, exp_val);
    end
    @(negedge us_clk);
    tests_run++;
    if (ch_fresh !== 4'b0000) begin
      tests_failed++;
      $display("FAIL basic_fresh_one_cycle: fresh=%b, want 0000", ch_fresh);
    end
  endtask

  task automatic test_round_robin();
    int exp_ch [3] = '{2, 3, 0};
    logic [15:0] exp_pw [3] = '{16'd1800, 16'd1100, 16'd1200};
    logic [7:0]  vals [3] = '{8'd200, 8'd25, 8'd50};
    int w; logic [15:0] pw; bit st; logic [3:0] fr; logic ra;
    pulse_us[15:0]  = 16'd1200;
    pulse_us[47:32] = 16'd1800;
    pulse_us[63:48] = 16'd1100;
    pulse_valid = 4'b1101;
    @(negedge us_clk);
    pulse_valid = '0;
    for (int g = 0; g < 3; g++) begin
      serve(5, vals[g], w, pw, st, fr, ra);
      exp_val[exp_ch[g]*8 +: 8] = vals[g];
      tests_run++;
      if (w >= 20 || pw !== exp_pw[g] || !st) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: waits=%0d pw=%0d stable=%b, want pw=%0d stable=1",
                 g, w, pw, st, exp_pw[g]);
      end
      tests_run++;
      if (fr !== 4'(1 << exp_ch[g]) || ch_val !== exp_val || ra !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_result%0d: fresh=%b val=%h req=%b, want ch%0d val=%h req=0",
                 g, fr, ch_val, ra, exp_ch[g], exp_val);
      end
    end
  endtask

  task automatic test_clamp();
    logic [15:0] in_pw [5] = '{16'd900, 16'd2300, 16'd1000, 16'd2000, 16'd999};
    logic [15:0] out_pw [5] = '{16'd1000, 16'd2000, 16'd1000, 16'd2000, 16'd1000};
    int w; logic [15:0] pw; bit st; logic [3:0] fr; logic ra;
    for (int t = 0; t < 5; t++) begin
      pulse_us[15:0] = in_pw[t];
      pulse_valid = 4'b0001;
      @(negedge us_clk);
      pulse_valid = '0;
      serve(1, 8'(t + 10), w, pw, st, fr, ra);
      exp_val[7:0] = 8'(t + 10);
      tests_run++;
      if (pw !== out_pw[t] || fr !== 4'b0001 || ch_val !== exp_val) begin
        tests_failed++;
        $display("FAIL clamp_%0d: pw=%0d fresh=%b val=%h, want pw=%0d fresh=0001 val=%h",
                 in_pw[t], pw, fr, ch_val, out_pw[t], exp_val);
      end
    end
  endtask

  task automatic test_reissue();
    int w; logic [15:0] pw; bit st; logic [3:0] fr; logic ra;
    pulse_us[31:16] = 16'd1500;
    pulse_valid = 4'b0010;
    @(negedge us_clk);
    pulse_valid = '0;
    @(negedge us_clk);
    pulse_us[31:16] = 16'd1600;
    pulse_valid = 4'b0010;
    @(negedge us_clk);
    pulse_valid = '0;
    serve(2, 8'd140, w, pw, st, fr, ra);
    exp_val[15:8] = 8'd140;
    tests_run++;
    if (pw !== 16'd1500 || !st || fr !== 4'b0010 || ch_val !== exp_val) begin
      tests_failed++;
      $display("FAIL reissue_first: pw=%0d stable=%b fresh=%b val=%h, want pw=1500 fresh=0010",
               pw, st, fr, ch_val);
    end
    serve(0, 8'd160, w, pw, st, fr, ra);
    exp_val[15:8] = 8'd160;
    tests_run++;
    if (w >= 20 || pw !== 16'd1600 || fr !== 4'b0010 || ch_val !== exp_val) begin
      tests_failed++;
      $display("FAIL reissue_second: waits=%0d pw=%0d fresh=%b val=%h, want pw=1600 val=%h",
               w, pw, fr, ch_val, exp_val);
    end
  endtask

  task automatic test_idle_ack();
    repeat (2) @(negedge us_clk);
    conv_value = 8'd77;
    conv_ack = 1'b1;
    @(negedge us_clk);
    conv_ack = 1'b0;
    tests_run++;
    if (ch_fresh !== 4'b0000 || ch_val !== exp_val || conv_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_ack_ignored: fresh=%b val=%h req=%b, want fresh=0000 val=%h req=0",
               ch_fresh, ch_val, conv_req, exp_val);
    end
  endtask

  task automatic test_link_default();
    int bad = 0;
    repeat (200) begin
      @(negedge us_clk);
      if (link_ok !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL link_stays_up: %0d cycles with link_ok low, want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    pulse_us[47:32] = 16'd1700;
    pulse_valid = 4'b0100;
    @(negedge us_clk);
    pulse_valid = '0;
    tests_run++;
    if (conv_req !== 1'b1 || conv_pulse_us !== 16'd1700) begin
      tests_failed++;
      $display("FAIL mid_req: req=%b pw=%0d, want req=1 pw=1700", conv_req, conv_pulse_us);
    end
    resetn = 1'b0;
    @(negedge us_clk);
    exp_val = '0;
    tests_run++;
    if ({conv_req, conv_pulse_us, ch_val, ch_fresh, link_ok} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: req=%b pw=%0d val=%h fresh=%b link=%b, want all zero",
               conv_req, conv_pulse_us, ch_val, ch_fresh, link_ok);
    end
    resetn = 1'b1;
    @(negedge us_clk);
    conv_value = 8'd99;
    conv_ack = 1'b1;
    @(negedge us_clk);
    conv_ack = 1'b0;
    tests_run++;
    if (ch_fresh !== 4'b0000 || ch_val !== 32'd0 || conv_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_ack_ignored: fresh=%b val=%h req=%b, want zeros", ch_fresh, ch_val, conv_req);
    end
    @(negedge us_clk);
    tests_run++;
    if (conv_req !== 1'b0 || conv_pulse_us !== 16'd0) begin
      tests_failed++;
      $display("FAIL no_request_after_reset: req=%b pw=%0d, want 0/0", conv_req, conv_pulse_us);
    end
  endtask

`ifdef RC_FAILSAFE_EN
  task automatic test_failsafe();
    int n = 0;
    int w; logic [15:0] pw; bit st; logic [3:0] fr; logic ra;
    pulse_us[15:0] = 16'd1500;
    pulse_valid = 4'b0001;
    @(negedge us_clk);
    pulse_valid = '0;
    tests_run++;
    if (link_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL fs_link_up: link_ok=%b, want 1", link_ok);
    end
    while (link_ok === 1'b1 && n < 61000) begin
      if (conv_req === 1'b1 && conv_ack !== 1'b1) begin
        conv_value = 8'd60;
        conv_ack = 1'b1;
      end else begin
        conv_ack = 1'b0;
      end
      @(negedge us_clk);
      n++;
    end
    conv_ack = 1'b0;
    tests_run++;
    if (n != 60000 || ch_fresh[0] !== 1'b1 || ch_val[7:0] !== 8'd0) begin
      tests_failed++;
      $display("FAIL fs_timeout: cycles=%0d fresh0=%b val0=%0d, want 60000/1/0",
               n, ch_fresh[0], ch_val[7:0]);
    end
    pulse_valid = 4'b0001;
    @(negedge us_clk);
    pulse_valid = '0;
    tests_run++;
    if (link_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL fs_link_restore: link_ok=%b, want 1", link_ok);
    end
    serve(0, 8'd90, w, pw, st, fr, ra);
    tests_run++;
    if (fr !== 4'b0001 || ch_val[7:0] !== 8'd90) begin
      tests_failed++;
      $display("FAIL fs_after_restore: fresh=%b val0=%0d, want 0001/90", fr, ch_val[7:0]);
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    pulse_valid = '0;
    pulse_us = '0;
    conv_ack = 1'b0;
    conv_value = '0;
    @(negedge us_clk);
    test_reset();
    test_basic();
    test_round_robin();
    test_clamp();
    test_reissue();
    test_idle_ack();
`ifndef RC_FAILSAFE_EN
    test_link_default();
`endif
    test_reset_mid();
`ifdef RC_FAILSAFE_EN
    test_failsafe();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
